// File: rtl/mult_hilo_ctrl.sv
// MULT/MULTU sequencer for an external combinational multiplier, with the HI/LO registers and MFHI/MFLO/MTHI/MTLO.
// Optional macro MULT_CANCEL_EN adds a cancel input that abandons an in-flight multiply.
module mult_hilo_ctrl #(
    parameter int MULT_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mfhi,
    input  logic        mflo,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        busy,
    output logic        mult_begin,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [63:0] product,
    input  logic        mult_end
`ifdef MULT_CANCEL_EN
    ,
    input  logic        cancel
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

    state_t            state_q, state_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       op1_q, op1_d;
    logic [31:0]       op2_q, op2_d;
    logic              sgn_q, sgn_d;
    logic [63:0]       res_q, res_d;
    logic [31:0]       corr;
    logic [63:0]       wb_val;
    logic              cancel_w;

`ifdef MULT_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // Unsigned fix-up only touches the upper word, so a 32-bit wrapping sum suffices.
    assign corr   = (op1_q[31] ? op2_q : 32'h0) + (op2_q[31] ? op1_q : 32'h0);
    assign wb_val = res_q + {(sgn_q ? 32'h0 : corr), 32'h0};

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sgn_d   = sgn_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (op_valid) begin
                    op1_d   = op_a;
                    op2_d   = op_b;
                    sgn_d   = op_signed;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST && mult_end) begin
                    res_d   = product;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                {hi_d, lo_d} = wb_val;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (cancel_w && state_q != S_IDLE) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sgn_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sgn_q   <= sgn_d;
            res_q   <= res_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign mult_begin = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign mult_op1   = op1_q;
    assign mult_op2   = op2_q;
    assign stall      = busy & (op_valid | mfhi | mflo | mthi | mtlo);
    assign rdata      = busy ? 32'h0 : (mfhi ? hi_q : (mflo ? lo_q : 32'h0));

endmodule
